// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with a built-in clear sweep.
// Entry 0 can be hardwired to zero (ZERO_REG), and a write can be forwarded
// to a read of the same entry on the same edge (BYPASS). Reads are registered.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_SWEEP | zeroing one entry per cycle from ptr 0 to DEPTH-1, busy_o=1
// S_READY | normal read/write; clr_i starts a new sweep
module regfile_2r1w #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  output logic             busy_o,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_a_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic             re_b_i,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o
);

  localparam logic [0:0]    S_SWEEP  = 1'b0;
  localparam logic [0:0]    S_READY  = 1'b1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q [2];
  logic [WIDTH-1:0] rdata_d [2];
  logic [1:0]       re;
  logic [AW-1:0]    ra [2];
  logic             ready;
  logic             wr_en;

  // An address is backed by storage only if it is in range and not the
  // hardwired-zero entry; the same test gates both writes and reads.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  assign ready  = (state_q == S_READY);
  assign busy_o = (state_q == S_SWEEP);
  assign wr_en  = ready && !clr_i && we_i && addr_ok(waddr_i);
  assign re     = {re_b_i, re_a_i};
  assign ra[0]  = raddr_a_i;
  assign ra[1]  = raddr_b_i;

  assign rdata_a_o = rdata_q[0];
  assign rdata_b_o = rdata_q[1];

  // Sweep sequencing: walk ptr to the last entry, then hand over to READY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_SWEEP: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = S_READY;
          ptr_d   = '0;
        end
      end
      default: begin
        if (clr_i) begin
          state_d = S_SWEEP;
          ptr_d   = '0;
        end
      end
    endcase
  end

  // Next read data per port; output is forced to zero from the first busy
  // cycle, so a clear request also suppresses any read issued with it.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_d[p] = rdata_q[p];
      if (!ready || clr_i) begin
        rdata_d[p] = '0;
      end else if (re[p]) begin
        if (!addr_ok(ra[p])) begin
          rdata_d[p] = '0;
        end else if (BYPASS && wr_en && (waddr_i == ra[p])) begin
          rdata_d[p] = wdata_i;
        end else begin
          rdata_d[p] = mem_q[ra[p]];
        end
      end
    end
  end

  // Control and read registers; the array itself is only cleared by the sweep.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_SWEEP;
      ptr_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  // Storage array: sweep writes zero, otherwise the qualified user write.
  always_ff @(posedge clk_i) begin
    if (!ready) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule
